// File: rtl/ram_checker.sv
`default_nettype none
// ============================================================================
// Module      : ram_checker
// Description : Read-back verifier for the cold-boot RAM clear. It reads every
//               byte of the window START_RAM..END_RAM over the SDRAM read
//               port and compares each byte with EXPECT. It reports pass/fail,
//               the first failing address and its data, and a timeout when
//               the SDRAM stops answering.
// Ports       : i_clk         system clock
//               i_reset_n     asynchronous active-low reset
//               i_ena         clock enable (nothing changes while low)
//               i_trigger     rising edge (on ena cycles) starts a check
//               o_checking    check in progress
//               o_done        result valid, held until the next start
//               o_pass        all bytes matched EXPECT
//               o_timeout     check aborted, SDRAM did not answer
//               o_fail_addr   first mismatching / timed-out address
//               o_fail_data   data read at o_fail_addr (0 on timeout)
//               o_rd          SDRAM read request, held until i_din_valid
//               o_addr        SDRAM byte address
//               i_din         SDRAM read data
//               i_din_valid   read data valid (only looked at in WAIT)
// Revision    : 1.0  initial release
// ============================================================================
module ram_checker #(
  parameter logic [24:0] START_RAM = 25'h8000,
  parameter logic [24:0] END_RAM   = 25'hFFFF,
  parameter logic [7:0]  EXPECT    = 8'hFF,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ena,
  input  logic        i_trigger,
  output logic        o_checking,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [24:0] o_fail_addr,
  output logic [7:0]  o_fail_data,
  output logic        o_rd,
  output logic [24:0] o_addr,
  input  logic [7:0]  i_din,
  input  logic        i_din_valid
);

  // Last WAIT count value before the request is abandoned.
  localparam logic [7:0] c_WCNT_LAST = TIMEOUT - 8'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [24:0] r_pos;
  logic [7:0]  r_wcnt;
  logic        r_trig_q;
  logic        r_checking;
  logic        r_done;
  logic        r_pass;
  logic        r_timeout;
  logic [24:0] r_fail_addr;
  logic [7:0]  r_fail_data;
  logic        r_rd;
  logic [24:0] r_addr;

  logic        w_start;

  assign w_start = i_trigger & ~r_trig_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_pos       <= 25'd0;
      r_wcnt      <= 8'd0;
      r_trig_q    <= 1'b0;
      r_checking  <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_addr <= 25'd0;
      r_fail_data <= 8'd0;
      r_rd        <= 1'b0;
      r_addr      <= 25'd0;
    end else if (i_ena) begin
      r_trig_q <= i_trigger;
      case (r_state)
        S_IDLE: begin
          // Start edges outside IDLE fall through and are simply lost.
          if (w_start) begin
            r_pos       <= START_RAM;
            r_checking  <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_addr <= 25'd0;
            r_fail_data <= 8'd0;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          r_rd    <= 1'b1;
          r_addr  <= r_pos;
          r_wcnt  <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_din_valid) begin
            r_rd <= 1'b0;
            if (i_din != EXPECT) begin
              r_fail_addr <= r_addr;
              r_fail_data <= i_din;
              r_state     <= S_DONE;
            end else if (r_pos == END_RAM) begin
              r_pass  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_pos   <= r_pos + 25'd1;
              r_state <= S_REQ;
            end
          end else if (r_wcnt == c_WCNT_LAST) begin
            r_rd        <= 1'b0;
            r_timeout   <= 1'b1;
            r_fail_addr <= r_addr;
            r_fail_data <= 8'd0;
            r_state     <= S_DONE;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        S_DONE: begin
          r_checking <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_checking  = r_checking;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_timeout   = r_timeout;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_data = r_fail_data;
  assign o_rd        = r_rd;
  assign o_addr      = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_ram_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_checker
// Description : Self-checking bench for ram_checker. Instance 1 checks a
//               512-byte window with a randomised SDRAM responder; instance 2
//               checks a single-byte window under a sparse clock enable.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ram_checker;

  localparam logic [24:0] S1    = 25'h8000;
  localparam logic [24:0] E1    = 25'h81FF;
  localparam logic [24:0] S2    = 25'h8000;
  localparam logic [24:0] E2    = 25'h8000;
  localparam logic [24:0] NONE  = 25'h1FFFFFF;
  localparam int          TMO   = 255;
  localparam int          LIMIT = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ena1, trig1, dv1, chk1, done1, pass1, to1, rd1;
  logic [24:0] fa1, addr1;
  logic [7:0]  fd1, din1;
  logic        ena2, trig2, dv2, chk2, done2, pass2, to2, rd2;
  logic [24:0] fa2, addr2;
  logic [7:0]  fd2, din2;

  // SDRAM model state
  logic [24:0] bad_addr   = NONE;
  logic [7:0]  bad_data   = 8'h00;
  logic [24:0] stall_addr = NONE;
  int          lat        = 0;
  int          lcnt1      = 0;

  int n_checks = 0;
  int n_fail   = 0;

  ram_checker #(.START_RAM(S1), .END_RAM(E1), .EXPECT(8'hFF), .TIMEOUT(8'd255)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ena(ena1), .i_trigger(trig1),
    .o_checking(chk1), .o_done(done1), .o_pass(pass1), .o_timeout(to1),
    .o_fail_addr(fa1), .o_fail_data(fd1), .o_rd(rd1), .o_addr(addr1),
    .i_din(din1), .i_din_valid(dv1)
  );

  ram_checker #(.START_RAM(S2), .END_RAM(E2), .EXPECT(8'hFF), .TIMEOUT(8'd255)) u_dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ena(ena2), .i_trigger(trig2),
    .o_checking(chk2), .o_done(done2), .o_pass(pass2), .o_timeout(to2),
    .o_fail_addr(fa2), .o_fail_data(fd2), .o_rd(rd2), .o_addr(addr2),
    .i_din(din2), .i_din_valid(dv2)
  );

  // SDRAM responder: answers `lat` cycles after rd rises, never at stall_addr.
  always @(posedge clk) lcnt1 <= rd1 ? lcnt1 + 1 : 0;
  assign dv1  = rd1 && (lcnt1 >= lat) && (addr1 != stall_addr);
  assign din1 = (addr1 == bad_addr) ? bad_data : 8'hFF;
  assign dv2  = rd2 && (addr2 != stall_addr);
  assign din2 = (addr2 == bad_addr) ? bad_data : 8'hFF;

  // Record the address of every new read request.
  logic [24:0] rdq1[$];
  logic        rd1_prev = 1'b0;
  logic        rd2_prev = 1'b0;
  int          rdn2     = 0;
  always @(negedge clk) begin
    if (rd1 && !rd1_prev) rdq1.push_back(addr1);
    if (rd2 && !rd2_prev) rdn2++;
    rd1_prev = rd1;
    rd2_prev = rd2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One check on instance 1 with ena=1; expectations come from walking the
  // window over the memory contents.
  task automatic do_run(input string tag, input logic [24:0] ba, input logic [7:0] bd,
                        input logic [24:0] sa, input int l);
    logic [24:0] stop;
    int          kind;  // 0 pass, 1 mismatch, 2 timeout
    int          nb, exp_cyc, n;
    logic        seq_ok;
    bad_addr = ba; bad_data = bd; stall_addr = sa; lat = l;
    rdq1.delete();
    kind = 0;
    stop = E1;
    for (logic [24:0] a = S1; a <= E1; a++) begin
      if (a == sa) begin kind = 2; stop = a; break; end
      if (((a == ba) ? bd : 8'hFF) != 8'hFF) begin kind = 1; stop = a; break; end
    end
    nb = int'(stop - S1);
    exp_cyc = (kind == 2) ? 2 + nb * (l + 2) + 1 + TMO : 2 + (nb + 1) * (l + 2);
    trig1 = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!done1 && n < LIMIT);
    trig1 = 1'b0;
    seq_ok = 1'b1;
    foreach (rdq1[i]) if (rdq1[i] != S1 + 25'(i)) seq_ok = 1'b0;
    chk({tag, "_cycles"},   n, exp_cyc);
    chk({tag, "_done"},     done1, 1'b1);
    chk({tag, "_checking"}, chk1, 1'b0);
    chk({tag, "_pass"},     pass1, kind == 0);
    chk({tag, "_timeout"},  to1, kind == 2);
    chk({tag, "_fail_addr"}, fa1, (kind == 0) ? 25'd0 : stop);
    chk({tag, "_fail_data"}, fd1, (kind == 1) ? bd : 8'h00);
    chk({tag, "_rd_idle"},  rd1, 1'b0);
    chk({tag, "_rd_count"}, rdq1.size(), nb + 1);
    chk({tag, "_rd_seq"},   seq_ok, 1'b1);
    tick();
  endtask

  initial begin
    int n;
    logic [62:0] snap;
    logic        was_ena;
    rst_n = 1'b0;
    ena1 = 1'b1; trig1 = 1'b0;
    ena2 = 1'b0; trig2 = 1'b0;
    repeat (2) tick();
    chk("reset_flags1", {chk1, done1, pass1, to1, rd1}, 5'd0);
    chk("reset_addr1",  {addr1, fa1, fd1}, 58'd0);
    chk("reset_all2",   {chk2, done2, pass2, to2, rd2, addr2, fa2, fd2}, 63'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full clean window, immediate response.
    do_run("pass_l0", NONE, 8'h00, NONE, 0);
    // Mismatch in the middle of the window.
    do_run("mismatch", S1 + 25'h0BC, 8'h00, NONE, 0);
    // SDRAM never answers at 0x8005.
    do_run("timeout", NONE, 8'h00, 25'h8005, 0);
    // Boundary bytes: first and last of the window.
    do_run("bad_first", S1, 8'h5A, NONE, 1);
    do_run("bad_last",  E1, 8'hFE, NONE, 2);
    // Random contents / latencies.
    for (int i = 0; i < 4; i++) begin
      logic [24:0] ba, sa;
      ba = S1 + 25'($urandom_range(0, 700));
      sa = ($urandom_range(0, 1) == 1) ? S1 + 25'($urandom_range(0, 700)) : NONE;
      do_run($sformatf("rand%0d", i), ba, 8'($urandom_range(0, 254)), sa, $urandom_range(0, 3));
    end

    // Reset in the middle of a check.
    bad_addr = NONE; stall_addr = NONE; lat = 0;
    trig1 = 1'b1;
    n = 0;
    while (!(rd1 && addr1 == S1 + 25'h40) && n < LIMIT) begin tick(); n++; end
    trig1 = 1'b0;
    chk("rst_reached_addr", addr1, S1 + 25'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_flags", {chk1, done1, pass1, to1, rd1}, 5'd0);
    chk("rst_async_addr",  {addr1, fa1, fd1}, 58'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_run("after_rst", NONE, 8'h00, NONE, 0);

    // Held trigger plus a second edge mid-run: only one run.
    rdq1.delete();
    lat = 1;
    trig1 = 1'b1;
    n = 0;
    repeat (20) begin tick(); n++; end
    trig1 = 1'b0; tick(); n++;
    trig1 = 1'b1;
    while (!done1 && n < LIMIT) begin tick(); n++; end
    chk("hold_cycles", n, 2 + (int'(E1 - S1) + 1) * 3);
    chk("hold_pass",   pass1, 1'b1);
    repeat (10) tick();
    chk("hold_done_kept", done1, 1'b1);
    chk("hold_checking",  chk1, 1'b0);
    chk("hold_single_run", rdq1.size(), int'(E1 - S1) + 1);
    trig1 = 1'b0; tick();
    trig1 = 1'b1; tick();
    chk("restart_done_cleared", {done1, pass1, chk1}, 3'b001);
    trig1 = 1'b0;
    n = 0;
    while (!done1 && n < LIMIT) begin tick(); n++; end
    chk("restart_pass", pass1, 1'b1);
    chk("restart_rd_count", rdq1.size(), 2 * (int'(E1 - S1) + 1));

    // Single-byte window under a 1-of-3 clock enable.
    bad_addr = NONE; stall_addr = NONE;
    rdn2 = 0;
    trig2 = 1'b1;
    for (int c = 0; c < 200 && !done2; c++) begin
      ena2 = (c % 3 == 0);
      was_ena = ena2;
      snap = {chk2, done2, pass2, to2, rd2, addr2, fa2, fd2};
      tick();
      if (!was_ena)
        chk($sformatf("ena_hold_c%0d", c), {chk2, done2, pass2, to2, rd2, addr2, fa2, fd2}, snap);
    end
    trig2 = 1'b0;
    chk("ena_done",     done2, 1'b1);
    chk("ena_pass",     pass2, 1'b1);
    chk("ena_timeout",  to2, 1'b0);
    chk("ena_fail",     {fa2, fd2}, 33'd0);
    chk("ena_rd_count", rdn2, 1);
    chk("ena_addr",     addr2, S2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
